tdc_meas_ctrl: RTL and testbench

//  Sequences one averaged TDC measurement: launches the delay line edge, waits a settle

---
 rtl/tdc_meas_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// Averaged TDC measurement sequencer: launch, settle, capture, popcount accumulate.
// Optional TDC_MEAS_MINMAX_EN adds per-measurement res_min/res_max outputs.
module tdc_meas_ctrl #(
   parameter int N        = 64,
   parameter int CNT_W    = $clog2(N) + 1,
   parameter int AVG_LOG2 = 2,
   parameter int SETTLE   = 3,
   parameter int POP_LAT  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      start,
   output logic                      launch,
   output logic                      capture,
   output logic                      pop_en,
   input  logic [CNT_W-1:0]          pop_y,
   output logic                      busy,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [CNT_W+AVG_LOG2-1:0] res_data,
   output logic                      res_ovf
`ifdef TDC_MEAS_MINMAX_EN
   ,
   output logic [CNT_W-1:0]          res_min,
   output logic [CNT_W-1:0]          res_max
`endif
);

   localparam int WMAX  = (SETTLE > POP_LAT) ? SETTLE : POP_LAT;
   localparam int WC_W  = $clog2(WMAX + 1);
   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_SETTLE, S_CAPTURE, S_WAIT_POP, S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [WC_W-1:0]     wcnt_q, wcnt_d;
   logic [AVG_LOG2-1:0] smp_q, smp_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                ovf_q, ovf_d;
   logic                launch_q, launch_d;
   logic                capture_q, capture_d;
   logic                valid_q, valid_d;
   logic                acc_en;
   logic                running;
`ifdef TDC_MEAS_MINMAX_EN
   logic [CNT_W-1:0]    min_q, min_d, max_q, max_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         smp_q     <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         launch_q  <= 1'b0;
         capture_q <= 1'b0;
         valid_q   <= 1'b0;
`ifdef TDC_MEAS_MINMAX_EN
         min_q     <= '0;
         max_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         smp_q     <= smp_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         launch_q  <= launch_d;
         capture_q <= capture_d;
         valid_q   <= valid_d;
`ifdef TDC_MEAS_MINMAX_EN
         min_q     <= min_d;
         max_q     <= max_d;
`endif
      end
   end

   assign running = state_q inside {S_LAUNCH, S_SETTLE, S_CAPTURE, S_WAIT_POP};

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      smp_d   = smp_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      acc_en  = 1'b0;
`ifdef TDC_MEAS_MINMAX_EN
      min_d   = min_q;
      max_d   = max_q;
`endif
      // Dropping ena mid-sequence abandons the partial sum entirely.
      if (running && !ena) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (ena && start) begin
                  state_d = S_LAUNCH;
                  acc_d   = '0;
                  smp_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            S_LAUNCH: begin
               state_d = S_SETTLE;
               wcnt_d  = WC_W'(SETTLE - 1);
            end
            S_SETTLE: begin
               if (wcnt_q == '0) state_d = S_CAPTURE;
               else              wcnt_d  = wcnt_q - 1'b1;
            end
            S_CAPTURE: begin
               state_d = S_WAIT_POP;
               wcnt_d  = WC_W'(POP_LAT - 1);
            end
            S_WAIT_POP: begin
               if (wcnt_q == '0) begin
                  acc_en  = 1'b1;
                  acc_d   = acc_q + {{AVG_LOG2{1'b0}}, pop_y};
                  ovf_d   = ovf_q | (pop_y == N_C);
                  smp_d   = smp_q + 1'b1;
                  state_d = (smp_q == '1) ? S_DONE : S_LAUNCH;
`ifdef TDC_MEAS_MINMAX_EN
                  if (smp_q == '0) begin
                     min_d = pop_y;
                     max_d = pop_y;
                  end else begin
                     if (pop_y < min_q) min_d = pop_y;
                     if (pop_y > max_q) max_d = pop_y;
                  end
`endif
               end else begin
                  wcnt_d = wcnt_q - 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      launch_d  = (state_d == S_LAUNCH);
      capture_d = (state_d == S_CAPTURE);
      valid_d   = (state_d == S_DONE);
   end

   assign launch    = launch_q;
   assign capture   = capture_q;
   assign pop_en    = capture_q;
   assign res_valid = valid_q;
   assign busy      = (state_q != S_IDLE);
   assign res_data  = acc_q;
   assign res_ovf   = ovf_q;
`ifdef TDC_MEAS_MINMAX_EN
   assign res_min   = min_q;
   assign res_max   = max_q;
`endif

   a_pop_range: assert property (
      @(posedge clk) disable iff (!rst_n) acc_en |-> (pop_y <= N_C)
   );

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl; datapath model returns seq[] two cycles after pop_en.
// Build with TDC_MEAS_MINMAX_EN to also check res_min/res_max.
module tb_tdc_meas_ctrl;

   localparam int N     = 64;
   localparam int CNT_W = 7;
   localparam int AVG   = 2;
   localparam int RES_W = CNT_W + AVG;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic             start;
   logic             launch;
   logic             capture;
   logic             pop_en;
   logic [CNT_W-1:0] pop_y;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [RES_W-1:0] res_data;
   logic             res_ovf;
`ifdef TDC_MEAS_MINMAX_EN
   logic [CNT_W-1:0] res_min;
   logic [CNT_W-1:0] res_max;
`endif

   int checks   = 0;
   int failures = 0;

   logic [CNT_W-1:0] seq [4];
   logic             model_clr;
   logic             pe_d1;
   int               idx;

   always #5 clk = ~clk;

   tdc_meas_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .start     (start),
      .launch    (launch),
      .capture   (capture),
      .pop_en    (pop_en),
      .pop_y     (pop_y),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_ovf   (res_ovf)
`ifdef TDC_MEAS_MINMAX_EN
      ,
      .res_min   (res_min),
      .res_max   (res_max)
`endif
   );

   // Registered popcount model: value valid only in the cycle it is due.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_d1 <= 1'b0;
         pop_y <= '0;
         idx   <= 0;
      end else begin
         pe_d1 <= pop_en;
         pop_y <= pe_d1 ? seq[idx[1:0]] : '0;
         if (model_clr)  idx <= 0;
         else if (pe_d1) idx <= idx + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      model_clr = 1'b1;
      tick();
      model_clr = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic accept();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({launch, capture, pop_en, busy, res_valid, res_ovf} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctl got=%b want=000000",
                  {launch, capture, pop_en, busy, res_valid, res_ovf});
      end
      checks++;
      if (res_data !== '0) begin
         failures++;
         $display("FAIL reset_data got=%0d want=0", res_data);
      end
      #10;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [4:0] got, want;
      seq = '{7'd10, 7'd10, 7'd10, 7'd10};
      do_start();
      for (int cyc = 0; cyc <= 28; cyc++) begin
         want = {(cyc < 28) && (cyc % 7 == 0),
                 (cyc % 7 == 4), (cyc % 7 == 4),
                 cyc == 28, 1'b1};
         got = {launch, capture, pop_en, res_valid, busy};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL basic_timeline cyc=%0d got=%b want=%b", cyc, got, want);
         end
         if (cyc < 28) tick();
      end
      checks++;
      if (res_data !== 9'd40 || res_ovf !== 1'b0) begin
         failures++;
         $display("FAIL basic_result data=%0d ovf=%b want 40/0", res_data, res_ovf);
      end
      accept();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_accept busy=%b valid=%b want 0/0", busy, res_valid);
      end
   endtask

   task automatic test_ovf_seq();
      bit ok;
      seq = '{7'd5, 7'd64, 7'd7, 7'd9};
      do_start();
      wait_valid(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL ovf_seq_timeout got=no_valid want=valid");
      end
      checks++;
      if (res_data !== 9'd85 || res_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_seq_result data=%0d ovf=%b want 85/1", res_data, res_ovf);
      end
`ifdef TDC_MEAS_MINMAX_EN
      checks++;
      if (res_min !== 7'd5 || res_max !== 7'd64) begin
         failures++;
         $display("FAIL ovf_seq_minmax min=%0d max=%0d want 5/64", res_min, res_max);
      end
`endif
      accept();
   endtask

   task automatic test_hold();
      bit ok;
      int bad;
      seq = '{7'd1, 7'd2, 7'd3, 7'd4};
      do_start();
      wait_valid(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL hold_timeout got=no_valid want=valid");
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         ena = (i >= 10);
         tick();
         if (res_valid !== 1'b1 || res_data !== 9'd10 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_stable bad_cycles=%0d want 0 (data=%0d)", bad, res_data);
      end
      start = 1'b1;
      accept();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_accept busy=%b valid=%b want 0/0", busy, res_valid);
      end
      start = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || launch !== 1'b0) begin
         failures++;
         $display("FAIL hold_start_ignored busy=%b launch=%b want 0/0", busy, launch);
      end
   endtask

   task automatic test_abort();
      bit ok;
      int launches, valids;
      seq = '{7'd10, 7'd10, 7'd10, 7'd10};
      do_start();
      for (int cyc = 0; cyc < 8; cyc++) tick();
      ena = 1'b0;
      tick();
      checks++;
      if ({busy, launch, capture, res_valid} !== 4'b0) begin
         failures++;
         $display("FAIL abort_idle got=%b want=0000", {busy, launch, capture, res_valid});
      end
      ena = 1'b1;
      launches = 0;
      valids = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (launch) launches++;
         if (res_valid) valids++;
      end
      checks++;
      if (launches != 0 || valids != 0) begin
         failures++;
         $display("FAIL abort_quiet launches=%0d valids=%0d want 0/0", launches, valids);
      end
      do_start();
      wait_valid(ok);
      checks++;
      if (!ok || res_data !== 9'd40 || res_ovf !== 1'b0) begin
         failures++;
         $display("FAIL abort_restart ok=%b data=%0d ovf=%b want 1/40/0", ok, res_data, res_ovf);
      end
      accept();
   endtask

   task automatic test_busy_reset();
      int launches;
      seq = '{7'd10, 7'd10, 7'd10, 7'd10};
      do_start();
      launches = 1;
      for (int cyc = 1; cyc <= 28; cyc++) begin
         start = (cyc == 3 || cyc == 10 || cyc == 17 || cyc == 24);
         tick();
         if (launch) launches++;
      end
      start = 1'b0;
      checks++;
      if (launches != 4 || res_valid !== 1'b1) begin
         failures++;
         $display("FAIL busy_start launches=%0d valid=%b want 4/1", launches, res_valid);
      end
      accept();
      seq = '{7'd64, 7'd10, 7'd10, 7'd10};
      do_start();
      for (int cyc = 0; cyc < 12; cyc++) tick();
      checks++;
      if (busy !== 1'b1 || res_data !== 9'd64 || res_ovf !== 1'b1) begin
         failures++;
         $display("FAIL midrun_state busy=%b data=%0d ovf=%b want 1/64/1", busy, res_data, res_ovf);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({launch, capture, pop_en, busy, res_valid, res_ovf} !== 6'b0 || res_data !== '0) begin
         failures++;
         $display("FAIL async_reset ctl=%b data=%0d want 000000/0",
                  {launch, capture, pop_en, busy, res_valid, res_ovf}, res_data);
      end
      #10;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_scale();
      bit ok;
      seq = '{7'd64, 7'd64, 7'd64, 7'd64};
      do_start();
      wait_valid(ok);
      checks++;
      if (!ok || res_data !== 9'd256 || res_ovf !== 1'b1) begin
         failures++;
         $display("FAIL full_scale ok=%b data=%0d ovf=%b want 1/256/1", ok, res_data, res_ovf);
      end
`ifdef TDC_MEAS_MINMAX_EN
      checks++;
      if (res_min !== 7'd64 || res_max !== 7'd64) begin
         failures++;
         $display("FAIL full_minmax min=%0d max=%0d want 64/64", res_min, res_max);
      end
`endif
      accept();
   endtask

   initial begin
      ena       = 1'b1;
      start     = 1'b0;
      res_ready = 1'b0;
      model_clr = 1'b0;
      seq       = '{7'd0, 7'd0, 7'd0, 7'd0};
      test_reset();
      test_basic();
      test_ovf_seq();
      test_hold();
      test_abort();
      test_busy_reset();
      test_full_scale();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
